// File: rtl/glyph_matrix_scan_if.sv
// ---------------------------------------------------------------------------
// glyph_matrix_scan_if
//
// Bundles the signals between the matrix scan driver, the glyph pixel lookup
// and the LED matrix itself.
//
//   sel_req    : requested glyph (0 blank, 1 'O', 2 'X'), may change any cycle
//   word       : pixel bit returned by the lookup for row/col/select
//   row, col   : pixel address presented to the lookup
//   select     : frame-synchronised glyph select presented to the lookup
//   led_row    : one-hot matrix row enable, 0 = blanked
//   led_col    : column data for the lit row, bit 15 = leftmost column
//   frame_done : one-cycle pulse at each frame wrap
//
// master : the scan driver (drives address and LED outputs)
// slave  : lookup / matrix / environment side
// ---------------------------------------------------------------------------
interface glyph_matrix_scan_if;
    logic [1:0]  sel_req;
    logic        word;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [1:0]  select;
    logic [15:0] led_row;
    logic [15:0] led_col;
    logic        frame_done;

    modport master (
        input  sel_req,
        input  word,
        output row,
        output col,
        output select,
        output led_row,
        output led_col,
        output frame_done
    );

    modport slave (
        output sel_req,
        output word,
        input  row,
        input  col,
        input  select,
        input  led_row,
        input  led_col,
        input  frame_done
    );
endinterface

// File: rtl/glyph_matrix_scan.sv
// ---------------------------------------------------------------------------
// glyph_matrix_scan
//
// Scan driver for a 16x16 LED dot matrix. For every matrix row it walks the
// 16 columns of the glyph lookup (one pixel per cycle, zero-latency lookup),
// shifts the returned pixels into a row buffer, then lights that row for
// DWELL cycles before moving on. The glyph select is only updated when the
// last row of a frame finishes, so a frame is always drawn from one glyph.
//
// Parameters:
//   DWELL : cycles each assembled row stays lit (>= 1)
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : glyph_matrix_scan_if.master (sel_req/word in; row, col, select,
//           led_row, led_col, frame_done out, all registered)
// ---------------------------------------------------------------------------
module glyph_matrix_scan #(
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    glyph_matrix_scan_if.master bus
);

    // Counter only needs to hold DWELL-1.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        LATCH   = 2'd1,
        DISPLAY = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [3:0]         row_q,        row_d;
    logic [3:0]         col_q,        col_d;
    logic [1:0]         select_q,     select_d;
    logic [15:0]        led_row_q,    led_row_d;
    logic [15:0]        led_col_q,    led_col_d;
    logic               frame_done_q, frame_done_d;
    logic [15:0]        shreg_q,      shreg_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            row_q        <= '0;
            col_q        <= '0;
            select_q     <= '0;
            led_row_q    <= '0;
            led_col_q    <= '0;
            frame_done_q <= 1'b0;
            shreg_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            select_q     <= select_d;
            led_row_q    <= led_row_d;
            led_col_q    <= led_col_d;
            frame_done_q <= frame_done_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        select_d     = select_q;
        led_row_d    = led_row_q;
        led_col_d    = led_col_q;
        frame_done_d = 1'b0;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            FETCH: begin
                // Column 0 is shifted in first, so it ends up in bit 15.
                shreg_d   = {shreg_q[14:0], bus.word};
                led_row_d = '0;
                if (col_q == 4'd15) begin
                    col_d   = 4'd0;
                    state_d = LATCH;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end

            LATCH: begin
                led_col_d = shreg_q;
                led_row_d = 16'd1 << row_q;
                cnt_d     = CNT_W'(DWELL - 1);
                state_d   = DISPLAY;
            end

            DISPLAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    led_row_d = '0;
                    row_d     = row_q + 4'd1;
                    state_d   = FETCH;
                    // Last row of the frame: this is the only point where a
                    // new glyph may be taken, so the next frame never tears.
                    if (row_q == 4'd15) begin
                        frame_done_d = 1'b1;
                        select_d     = bus.sel_req;
                    end
                end
            end

            default: begin
                state_d   = FETCH;
                led_row_d = '0;
            end
        endcase
    end

    assign bus.row        = row_q;
    assign bus.col        = col_q;
    assign bus.select     = select_q;
    assign bus.led_row    = led_row_q;
    assign bus.led_col    = led_col_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_glyph_matrix_scan.sv
// ---------------------------------------------------------------------------
// tb_glyph_matrix_scan
//
// Drives two scan drivers (DWELL=4 and DWELL=1) from a shared clock, reset
// and sel_req, each backed by a behavioural glyph lookup. A model process
// predicts the full visible state from the cycle number since reset and the
// select latched at each frame wrap, and queues it; a monitor pops and
// compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_glyph_matrix_scan;

    localparam int DWELL_A = 4;
    localparam int DWELL_B = 1;

    localparam logic [15:0] GLYPH_O [16] = '{
        16'h0000, 16'h0000, 16'h0FF0, 16'h1FF8,
        16'h3C3C, 16'h381C, 16'h381C, 16'h381C,
        16'h381C, 16'h381C, 16'h381C, 16'h3C3C,
        16'h1FF8, 16'h3FFC, 16'h0000, 16'h0000
    };

    localparam logic [15:0] GLYPH_X [16] = '{
        16'hC003, 16'hE007, 16'h700E, 16'h381C,
        16'h1C38, 16'h0E70, 16'h07E0, 16'h03C0,
        16'h03C0, 16'h07E0, 16'h0E70, 16'h1C38,
        16'h381C, 16'h700E, 16'hE007, 16'hC003
    };

    typedef struct {
        logic        lit;
        logic [15:0] led_row;
        logic [15:0] led_col;
        logic        frame_done;
        logic [1:0]  select;
        logic [3:0]  row;
        logic [3:0]  col;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sel_req = 2'd1;

    int tests_run = 0;
    int tests_failed = 0;

    exp_t exp_q_a [$];
    exp_t exp_q_b [$];

    glyph_matrix_scan_if bus_a ();
    glyph_matrix_scan_if bus_b ();

    glyph_matrix_scan #(.DWELL(DWELL_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    glyph_matrix_scan #(.DWELL(DWELL_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    function automatic logic [15:0] glyph_row(input logic [1:0] sel, input logic [3:0] r);
        case (sel)
            2'd1:    return GLYPH_O[r];
            2'd2:    return GLYPH_X[r];
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic glyph_bit(input logic [1:0] sel, input logic [3:0] r, input logic [3:0] c);
        logic [15:0] w;
        w = glyph_row(sel, r);
        return w[4'd15 - c];
    endfunction

    assign bus_a.sel_req = sel_req;
    assign bus_b.sel_req = sel_req;
    assign bus_a.word    = glyph_bit(bus_a.select, bus_a.row, bus_a.col);
    assign bus_b.word    = glyph_bit(bus_b.select, bus_b.row, bus_b.col);

    // Visible state c edges after reset release: each row is 16 fetch
    // cycles, one latch cycle, then dwell lit cycles.
    function automatic exp_t model_at(input int c, input int dwell, input logic [1:0] sel);
        exp_t e;
        int period;
        int p;
        int r;
        int q;
        period       = 17 + dwell;
        p            = c % (16 * period);
        r            = p / period;
        q            = p % period;
        e.row        = 4'(r);
        e.col        = (q < 16) ? 4'(q) : 4'd0;
        e.lit        = (q >= 17);
        e.led_row    = e.lit ? (16'd1 << r) : 16'd0;
        e.led_col    = glyph_row(sel, 4'(r));
        e.frame_done = (c > 0) && (p == 0);
        e.select     = sel;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic compareState(input string pfx, input exp_t e,
                                input logic [15:0] led_row, input logic [15:0] led_col,
                                input logic frame_done, input logic [1:0] select,
                                input logic [3:0] row, input logic [3:0] col);
        checkOutput({pfx, ".led_row"},    led_row,          e.led_row);
        checkOutput({pfx, ".frame_done"}, 16'(frame_done),  16'(e.frame_done));
        checkOutput({pfx, ".select"},     16'(select),      16'(e.select));
        checkOutput({pfx, ".row"},        16'(row),         16'(e.row));
        checkOutput({pfx, ".col"},        16'(col),         16'(e.col));
        if (e.lit) checkOutput({pfx, ".led_col"}, led_col, e.led_col);
    endtask

    // Reference model: cycle count since release plus the select captured
    // at each frame wrap. Reset is only asserted while clk is low, so a
    // trigger with clk high is always a clock edge.
    initial begin
        int cyc_a;
        int cyc_b;
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        cyc_a = 0; cyc_b = 0; sel_a = 2'd0; sel_b = 2'd0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc_a = 0; cyc_b = 0; sel_a = 2'd0; sel_b = 2'd0;
                exp_q_a.delete();
                exp_q_b.delete();
                if (clk) begin
                    exp_q_a.push_back(model_at(0, DWELL_A, 2'd0));
                    exp_q_b.push_back(model_at(0, DWELL_B, 2'd0));
                end
            end else begin
                cyc_a++;
                cyc_b++;
                if (cyc_a % (16 * (17 + DWELL_A)) == 0) sel_a = sel_req;
                if (cyc_b % (16 * (17 + DWELL_B)) == 0) sel_b = sel_req;
                exp_q_a.push_back(model_at(cyc_a, DWELL_A, sel_a));
                exp_q_b.push_back(model_at(cyc_b, DWELL_B, sel_b));
            end
        end
    end

    // Monitor: one expected entry per clock, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q_a.size() > 0) begin
                e = exp_q_a.pop_front();
                compareState("A", e, bus_a.led_row, bus_a.led_col, bus_a.frame_done,
                             bus_a.select, bus_a.row, bus_a.col);
            end
            if (exp_q_b.size() > 0) begin
                e = exp_q_b.pop_front();
                compareState("B", e, bus_b.led_row, bus_b.led_col, bus_b.frame_done,
                             bus_b.select, bus_b.row, bus_b.col);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] value, input int cycles);
        sel_req = value;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkResetState();
        checkOutput("rst.A.led_row", bus_a.led_row,    16'h0000);
        checkOutput("rst.A.led_col", bus_a.led_col,    16'h0000);
        checkOutput("rst.A.row",     16'(bus_a.row),   16'h0000);
        checkOutput("rst.A.col",     16'(bus_a.col),   16'h0000);
        checkOutput("rst.A.select",  16'(bus_a.select), 16'h0000);
        checkOutput("rst.A.fdone",   16'(bus_a.frame_done), 16'h0000);
        checkOutput("rst.B.led_row", bus_b.led_row,    16'h0000);
        checkOutput("rst.B.led_col", bus_b.led_col,    16'h0000);
        checkOutput("rst.B.row",     16'(bus_b.row),   16'h0000);
        checkOutput("rst.B.col",     16'(bus_b.col),   16'h0000);
    endtask

    // Stimulus: fixed frames for the glyph checks, a mid-frame sel_req
    // toggle, randomised sel_req, then a reset during row 7's dwell.
    initial begin
        bit found;
        int first_lit;

        sel_req = 2'd1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState();
        rst_n = 1'b1;

        applyStimulus(2'd1, 400);
        applyStimulus(2'd2, 400);
        applyStimulus(2'd1, 100);
        applyStimulus(2'd2, 100);
        applyStimulus(2'd1, 100);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'($urandom_range(0, 2)), int'($urandom_range(20, 300)));
        end

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (bus_a.led_row == 16'h0080) found = 1'b1;
        end
        checkOutput("wait_row7_lit", 16'(found), 16'h0001);

        #1 rst_n = 1'b0;
        #1 checkResetState();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        first_lit = 0;
        for (int i = 1; i <= 100 && first_lit == 0; i++) begin
            @(negedge clk);
            if (bus_a.led_row != 16'h0000) begin
                first_lit = i;
                checkOutput("first_lit_row", bus_a.led_row, 16'h0001);
            end
        end
        checkOutput("first_lit_cycle", 16'(first_lit), 16'd17);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(2'($urandom_range(0, 2)), int'($urandom_range(50, 200)));
        end
        applyStimulus(2'd2, 700);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/glyph_matrix_scan.md
Name: glyph_matrix_scan

Overview:
Scan driver for the 16x16 LED dot matrix. It reads the glyph pixel source one column at a time by driving row, col and select. It samples the returned pixel bit, assembles each 16-pixel row and drives that row onto the matrix for a programmable dwell time. It is the consumer side of the row/col/select -> word glyph lookup. The glyph choice changes only on frame boundaries, so the display never tears.

Parameters:
DWELL, 4, number of clock cycles each assembled row is lit (must be >= 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
sel_req  input  2  requested glyph (0 = blank, 1 = 'O', 2 = 'X'); may change any cycle
word  input  1  pixel bit returned by glyph lookup for current row/col/select (combinational, same cycle)
row  output  4  pixel row address to glyph lookup (registered)
col  output  4  pixel column address to glyph lookup (registered)
select  output  2  frame-synchronised glyph select to glyph lookup (registered)
led_row  output  16  one-hot row enable; bit r lights matrix row r; 0 = blanked
led_col  output  16  column data of lit row; bit 15 = column 0 (leftmost), bit 0 = column 15
frame_done  output  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (async, rst_n=0): state=FETCH, row=0, col=0, select=0, led_row=0, led_col=0, frame_done=0, shift register=0, dwell counter=0. Reset mid-row or mid-frame aborts immediately; the frame restarts at row 0, col 0 after release.
- Lookup latency 0: in each FETCH cycle, word reflects the current registered row/col/select and is sampled at that cycle's rising edge.
- FETCH (16 cycles per row): each edge shreg <= {shreg[14:0], word}. If col==15, col <= 0 and go to LATCH; otherwise col <= col+1. led_row stays 0 (blanked) throughout FETCH.
- LATCH (1 cycle): at the edge, led_col <= shreg, led_row <= 1<<row, counter <= DWELL-1, go to DISPLAY.
- DISPLAY (DWELL cycles): led_row/led_col hold. At an edge with counter!=0, counter decrements.
- At the edge with counter==0 in DISPLAY:
  - led_row <= 0 (led_col holds last value; don't care while blanked).
  - row <= row+1, wrapping 15 -> 0; go to FETCH.
- Frame wrap (leaving DISPLAY with row==15): at that same edge, frame_done <= 1 for exactly one cycle and select <= sel_req. The new frame's first FETCH cycle therefore already uses the new select.
- select never changes at any other time. A sel_req change mid-frame is held off until the next wrap; intermediate sel_req values between wraps are ignored.
- frame_done is 0 in every other cycle.
- Timing:
  - Row period = 17 + DWELL cycles; frame period = 16*(17+DWELL) cycles (336 at DWELL=4).
  - led_row is nonzero for exactly DWELL consecutive cycles per row and is never multi-hot.
  - At least 17 blank cycles separate consecutive lit rows (anti-ghosting).
- select=0: the lookup returns 0, so led_col=0 every row, but scanning and timing are unchanged.
- The state encoding is internal; an illegal state recovers to FETCH on the next edge.

Test Plan:
1. Reset, sel_req=1, DWELL=4, run one frame: frame 0 uses select=0, so every lit row has led_col=0x0000. At the first frame_done, select becomes 1.
2. Frame 1 with select=1: led_row=0x0004 lit with led_col=0x0FF0; led_row=0x2000 lit with led_col=0x3FFC; led_row=0x0001 lit with led_col=0x0000.
3. sel_req=2 frame: led_row=0x0002 with led_col=0xE007; led_row=0x0080 with led_col=0x03C0. Also check col sweeps 0..15 in order during each FETCH.
4. Toggle sel_req 1->2->1 within a frame: select stays constant until frame_done, then takes the value of sel_req on that cycle. frame_done period is 336 cycles and the pulse is 1 cycle wide.
5. Assert rst_n low during DISPLAY of row 7: led_row=0, led_col=0, row=0, col=0 immediately with no clock. After release, the first lit row is row 0 at cycle 17.
6. DWELL=1 build: each row is lit for exactly 1 cycle, the row period is 18 cycles, and led_row is never nonzero during FETCH.
